pci_target_buffer: RTL and testbench

PCI-style target that owns a small word-addressed storage buffer. It decodes memory read and write commands on a multiplexed address/data bus and answers with DEVSEL#/TRDY# handshakes. Write bursts are stored with per-byte enables; read bursts stream the stored words back onto the shared bus. It sits on the bus next to an initiator and the free-running bench clock generator (`clockGen`, 10 ns period).

---
 rtl/pci_target_buffer.sv | 134 +++++++++++++
 tb/tb_pci_target_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pci_target_buffer.sv
// PCI-style memory target over a DEPTH-word buffer; optional per-byte write enables with `BUFFER_BYTE_ENABLE_EN.
// Registered outputs: write TRDY# from the address edge, read TRDY#/AD one turnaround later; IRDY# high stalls the burst.
module pci_target_buffer #(
  parameter logic [31:0] BASE_ADDR = 32'd1000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  input  logic        IRDY,
  output logic        TRDY,
  output logic        DEVSEL
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CMD_MRD = 4'b0110;
  localparam logic [3:0] CMD_MWR = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_TAR, S_DATA, S_SKIP} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [IW-1:0] r_idx, w_idx_nxt, w_idx_inc, w_addr_idx;
  logic          r_is_wr, w_is_wr_nxt;
  logic          r_trdy, w_trdy_nxt;
  logic          r_devsel, w_devsel_nxt;
  logic          r_oe, w_oe_nxt;
  logic [31:0]   r_ad, w_ad_nxt;
  logic [31:0]   w_offset;
  logic          w_in_range, w_xfer, w_we;
  logic [3:0]    w_be;

  assign w_offset   = AD - BASE_ADDR;
  assign w_in_range = (AD >= BASE_ADDR) && (w_offset < 32'(4 * DEPTH));
  assign w_addr_idx = w_offset[IW+1:2];
  assign w_idx_inc  = (r_idx == IW'(DEPTH - 1)) ? '0 : r_idx + IW'(1);
  assign w_xfer     = (r_state == S_DATA) && !IRDY && !r_trdy;

`ifdef BUFFER_BYTE_ENABLE_EN
  assign w_be = ~CBE;
`else
  assign w_be = 4'hF;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_is_wr_nxt  = r_is_wr;
    w_trdy_nxt   = r_trdy;
    w_devsel_nxt = r_devsel;
    w_oe_nxt     = r_oe;
    w_ad_nxt     = r_ad;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!frame) begin
          w_idx_nxt   = w_addr_idx;
          w_is_wr_nxt = (CBE == CMD_MWR);
          if (w_in_range && CBE == CMD_MWR) begin
            w_state_nxt  = S_DATA;
            w_devsel_nxt = 1'b0;
            w_trdy_nxt   = 1'b0;
          end else if (w_in_range && CBE == CMD_MRD) begin
            w_state_nxt  = S_TAR;
            w_devsel_nxt = 1'b0;
          end else begin
            w_state_nxt = S_SKIP;
          end
        end
      end
      S_TAR: begin
        w_state_nxt = S_DATA;
        w_trdy_nxt  = 1'b0;
        w_oe_nxt    = 1'b1;
        w_ad_nxt    = r_mem[r_idx];
      end
      S_DATA: begin
        if (w_xfer) begin
          w_idx_nxt = w_idx_inc;
          w_we      = r_is_wr;
          if (!r_is_wr) w_ad_nxt = r_mem[w_idx_inc];
        end
        // A completed phase with FRAME# high is the last; an idle bus also ends the burst.
        if ((w_xfer && frame) || (frame && IRDY)) begin
          w_state_nxt  = S_IDLE;
          w_trdy_nxt   = 1'b1;
          w_devsel_nxt = 1'b1;
          w_oe_nxt     = 1'b0;
        end
      end
      S_SKIP: begin
        if (frame && IRDY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_is_wr  <= 1'b0;
      r_trdy   <= 1'b1;
      r_devsel <= 1'b1;
      r_oe     <= 1'b0;
      r_ad     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_is_wr  <= w_is_wr_nxt;
      r_trdy   <= w_trdy_nxt;
      r_devsel <= w_devsel_nxt;
      r_oe     <= w_oe_nxt;
      r_ad     <= w_ad_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= AD[8*b +: 8];
      end
    end
  end

  assign AD     = r_oe ? r_ad : 'z;
  assign TRDY   = r_trdy;
  assign DEVSEL = r_devsel;

endmodule

// File: tb/tb_pci_target_buffer.sv
// Directed bus transactions against pci_target_buffer; read data checked by a queue-based monitor.
// The bench parks a probe pattern on AD whenever the target must not drive, so any target drive shows up.
module tb_pci_target_buffer;

  localparam logic [31:0] PROBE   = 32'h5A5A_C3C3;
  localparam logic [3:0]  CMD_MRD = 4'b0110;
  localparam logic [3:0]  CMD_MWR = 4'b0111;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b1;
  logic        IRDY  = 1'b1;
  logic [3:0]  CBE   = 4'h0;
  logic        tb_oe = 1'b1;
  logic [31:0] tb_ad = PROBE;
  wire  [31:0] AD;
  logic        TRDY, DEVSEL;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] wd [8];
  logic [3:0]  wc [8];
  logic [31:0] rexp [8];
  logic [31:0] w1_exp;

  assign AD = tb_oe ? tb_ad : 32'bz;
  always #5 clk = ~clk;

  pci_target_buffer #(.BASE_ADDR(32'd1000), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .frame (frame),
    .CBE   (CBE),
    .AD    (AD),
    .IRDY  (IRDY),
    .TRDY  (TRDY),
    .DEVSEL(DEVSEL)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Read data is compared whenever a completing data phase is visible on the bus.
  always @(negedge clk) begin
    if (rst_n && !TRDY && !IRDY && !tb_oe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_read_word: got %h required none", AD);
      end else begin
        mon_exp = exp_q.pop_front();
        check("read_data", AD, mon_exp);
      end
    end
  end

  task automatic idle(input int n);
    frame = 1'b1; IRDY = 1'b1; tb_oe = 1'b1; tb_ad = PROBE; CBE = 4'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [3:0] cmd, input logic [31:0] addr);
    frame = 1'b0; CBE = cmd; tb_oe = 1'b1; tb_ad = addr; IRDY = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input int n);
    addr_phase(CMD_MWR, addr);
    check_bit("wr_devsel_k", DEVSEL, 1'b0);
    check_bit("wr_trdy_k", TRDY, 1'b0);
    for (int i = 0; i < n; i++) begin
      frame = (i == n - 1); CBE = wc[i]; tb_ad = wd[i]; IRDY = 1'b0;
      @(posedge clk); #1;
    end
    check_bit("wr_end_trdy", TRDY, 1'b1);
    check_bit("wr_end_devsel", DEVSEL, 1'b1);
    idle(1);
  endtask

  task automatic bus_read(input logic [31:0] addr, input int n, input int wait_at, input int wait_n);
    addr_phase(CMD_MRD, addr);
    check_bit("rd_devsel_k", DEVSEL, 1'b0);
    check_bit("rd_trdy_tar", TRDY, 1'b1);
    for (int i = 0; i < n; i++) exp_q.push_back(rexp[i]);
    tb_oe = 1'b0; IRDY = 1'b0; frame = (n == 1); CBE = 4'hF;
    @(posedge clk); #1;
    check_bit("rd_trdy_k1", TRDY, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == wait_at) begin
        IRDY = 1'b1; frame = 1'b0;
        repeat (wait_n) begin
          @(posedge clk); #1;
          check("rd_wait_hold", AD, rexp[i]);
          check_bit("rd_wait_trdy", TRDY, 1'b0);
        end
        IRDY = 1'b0;
      end
      frame = (i == n - 1);
      @(posedge clk); #1;
    end
    check_bit("rd_end_trdy", TRDY, 1'b1);
    check_bit("rd_end_devsel", DEVSEL, 1'b1);
    frame = 1'b1; IRDY = 1'b1; tb_oe = 1'b1; tb_ad = PROBE;
    #1;
    check("rd_end_release", AD, PROBE);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    idle(1);
  endtask

  task automatic bus_unclaimed(input logic [3:0] cmd, input logic [31:0] addr, input int n);
    addr_phase(cmd, addr);
    for (int i = 0; i < n; i++) begin
      tb_ad = PROBE; CBE = 4'h0; frame = (i == n - 1); IRDY = 1'b0;
      #1;
      check_bit("unclaimed_devsel", DEVSEL, 1'b1);
      check_bit("unclaimed_trdy", TRDY, 1'b1);
      check("unclaimed_ad", AD, PROBE);
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle bus
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_trdy", TRDY, 1'b1);
    check_bit("rst_devsel", DEVSEL, 1'b1);
    check("rst_ad", AD, PROBE);
    rst_n = 1'b1;
    idle(2);
    check_bit("idle_trdy", TRDY, 1'b1);
    check_bit("idle_devsel", DEVSEL, 1'b1);
    check("idle_ad", AD, PROBE);
    for (int i = 0; i < 4; i++) rexp[i] = 32'h0;
    bus_read(32'd1000, 4, -1, 0);

    // Byte-enabled three-phase write
    wd[0] = 32'hAAAA_AAAA; wc[0] = 4'b0010;
    wd[1] = 32'hCCCC_CCCC; wc[1] = 4'b1111;
    wd[2] = 32'hDDDD_DDDD; wc[2] = 4'b0010;
    bus_write(32'd1000, 3);
`ifdef BUFFER_BYTE_ENABLE_EN
    rexp[0] = 32'hAAAA_00AA; rexp[1] = 32'h0000_0000; rexp[2] = 32'hDDDD_00DD;
`else
    rexp[0] = 32'hAAAA_AAAA; rexp[1] = 32'hCCCC_CCCC; rexp[2] = 32'hDDDD_DDDD;
`endif
    bus_read(32'd1000, 3, -1, 0);

    // Wrap-around read from the last word
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) wc[i] = 4'b0000;
    bus_write(32'd1000, 4);
    rexp[0] = 32'h4444_4444; rexp[1] = 32'h1111_1111;
    bus_read(32'd1012, 2, -1, 0);

    // Single-phase partial write, then a read with wait states
    wd[0] = 32'hFFFF_FFFF; wc[0] = 4'b1010;
    bus_write(32'd1004, 1);
`ifdef BUFFER_BYTE_ENABLE_EN
    w1_exp = 32'h22FF_22FF;
`else
    w1_exp = 32'hFFFF_FFFF;
`endif
    rexp[0] = 32'h1111_1111; rexp[1] = w1_exp; rexp[2] = 32'h3333_3333; rexp[3] = 32'h4444_4444;
    bus_read(32'd1000, 4, 2, 2);

    // Unclaimed commands and addresses
    bus_unclaimed(4'b0010, 32'd1000, 3);
    bus_unclaimed(CMD_MRD, 32'd2000, 2);
    bus_unclaimed(CMD_MWR, 32'd1016, 2);
    rexp[0] = 32'h1111_1111; rexp[1] = w1_exp;
    bus_read(32'd1000, 2, -1, 0);
    rexp[0] = 32'h1111_1111;
    bus_read(32'd1000, 1, -1, 0);

    // Reset mid-write burst
    addr_phase(CMD_MWR, 32'd1000);
    frame = 1'b0; CBE = 4'h0; tb_ad = 32'h1234_5678; IRDY = 1'b0;
    @(posedge clk); #1;
    check_bit("pre_rst_devsel", DEVSEL, 1'b0);
    tb_ad = PROBE;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_trdy", TRDY, 1'b1);
    check_bit("midrst_devsel", DEVSEL, 1'b1);
    check("midrst_ad", AD, PROBE);
    frame = 1'b1; IRDY = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) rexp[i] = 32'h0;
    bus_read(32'd1000, 4, -1, 0);

    idle(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
